// File: rtl/relu_round_ctrl.sv
// Drains one layer of accumulator results through the external relu_rounding unit
// into the activation buffer. Optional saturation counter: RELU_ROUND_CTRL_SATCNT_EN.
module relu_round_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int Q          = 16,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_out,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    input  logic [DATA_WIDTH-1:0] acc_data,
    output logic [DATA_WIDTH-1:0] rr_in,
    input  logic [Q-1:0]          rr_out,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [Q-1:0]          wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      sat_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  num_q, a_idx, w_idx;
    logic [ADDR_W-1:0] base_q;
    logic              s1_v;
    logic              accept, start_acc;

    assign accept    = acc_valid && (state == RUN);
    assign start_acc = start && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (num_out == '0) ? DONE : RUN;
            end
            RUN: begin
                acc_ready = 1'b1;
                if (acc_valid && (a_idx == num_q - CNT_W'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_idx == num_q) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1 captures the operand for relu_rounding; stage 2 registers its result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q   <= '0;
            base_q  <= '0;
            a_idx   <= '0;
            w_idx   <= '0;
            s1_v    <= 1'b0;
            rr_in   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            s1_v  <= accept;
            wr_en <= s1_v;
            if (accept) begin
                rr_in <= acc_data;
                a_idx <= a_idx + CNT_W'(1);
            end
            if (s1_v) begin
                wr_data <= rr_out;
                wr_addr <= base_q + ADDR_W'(w_idx);
                w_idx   <= w_idx + CNT_W'(1);
            end
            if (start_acc) begin
                num_q  <= num_out;
                base_q <= base_addr;
                a_idx  <= '0;
                w_idx  <= '0;
            end
        end
    end

`ifdef RELU_ROUND_CTRL_SATCNT_EN
    localparam logic [Q-1:0] SAT_POS = {1'b0, {(Q-1){1'b1}}};
    localparam logic [Q-1:0] SAT_NEG = {1'b1, {(Q-1){1'b0}}};

    logic [CNT_W-1:0] sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_q <= '0;
        else if (start_acc)
            sat_q <= '0;
        else if (s1_v && ((rr_out == SAT_POS) || (rr_out == SAT_NEG)))
            sat_q <= sat_q + CNT_W'(1);
    end

    assign sat_count = sat_q;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_relu_round_ctrl.sv
// Directed bench for relu_round_ctrl; models relu_rounding as rr_in[15:0] ^ 16'h00FF.
module tb_relu_round_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  num_out;
    logic [7:0]  base_addr;
    logic        acc_valid;
    logic        acc_ready;
    logic [31:0] acc_data;
    logic [31:0] rr_in;
    logic [15:0] rr_out;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic [8:0]  sat_count;

    logic        sat_mode = 1'b0;
    logic [15:0] sat_tab [4];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;

    logic [7:0]  wa_q [$];
    logic [15:0] wd_q [$];
    int          wc_q [$];
    int          dn_q [$];

    relu_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_out   (num_out),
        .base_addr (base_addr),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .rr_in     (rr_in),
        .rr_out    (rr_out),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    assign rr_out = sat_mode ? sat_tab[rr_in[1:0]] : (rr_in[15:0] ^ 16'h00FF);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (done) dn_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        dn_q.delete();
    endtask

    task automatic do_start(input logic [8:0] n, input logic [7:0] b);
        start     = 1'b1;
        num_out   = n;
        base_addr = b;
        tick();
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (!done && k < lim) begin
            tick();
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic chk_wr(input int i, input logic [7:0] a, input logic [15:0] d, input int c);
        if (i < wa_q.size()) begin
            chk("wr_addr", 32'(wa_q[i]), 32'(a));
            chk("wr_data", 32'(wd_q[i]), 32'(d));
            chk("wr_cycle", 32'(wc_q[i] - t0), 32'(c));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_acc_ready"}, 32'(acc_ready), 32'd0);
        chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_rr_in"},     rr_in,          32'd0);
        chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
        chk({tag, "_wr_data"},   32'(wr_data),   32'd0);
        chk({tag, "_sat_count"}, 32'(sat_count), 32'd0);
    endtask

    initial begin
        logic [5:0] bp_pat;
        rst = 1'b1; start = 1'b0; num_out = '0; base_addr = '0;
        acc_valid = 1'b0; acc_data = '0;
        sat_tab[0] = 16'h7FFF; sat_tab[1] = 16'h1234;
        sat_tab[2] = 16'h8000; sat_tab[3] = 16'h7FFF;
        tick(); tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic layer: 4 back-to-back results at base 0x10
        clr();
        do_start(9'd4, 8'h10);
        chk("basic_ready", 32'(acc_ready), 32'd1);
        acc_valid = 1'b1;
        acc_data = 32'h1; tick();
        acc_data = 32'h2; tick();
        acc_data = 32'h3; tick();
        acc_data = 32'h4; tick();
        acc_valid = 1'b0;
        chk("basic_ready_off", 32'(acc_ready), 32'd0);
        wait_done(10);
        tick();
        chk("basic_busy_fall", 32'(busy), 32'd0);
        chk("basic_wr_count", 32'(wa_q.size()), 32'd4);
        chk_wr(0, 8'h10, 16'h00FE, 2);
        chk_wr(1, 8'h11, 16'h00FD, 3);
        chk_wr(2, 8'h12, 16'h00FC, 4);
        chk_wr(3, 8'h13, 16'h00FB, 5);
        chk("basic_done_count", 32'(dn_q.size()), 32'd1);
        if (dn_q.size() > 0) chk("basic_done_cycle", 32'(dn_q[0] - t0), 32'd6);

        // Backpressure: valid pattern 1,0,0,1,0,1 -> accepts at 1,4,6
        clr();
        do_start(9'd3, 8'h20);
        bp_pat = 6'b101001;
        acc_data = 32'hA; acc_valid = bp_pat[0]; tick();
        acc_data = 32'hB; acc_valid = bp_pat[1]; tick();
        acc_valid = bp_pat[2]; tick();
        acc_valid = bp_pat[3]; tick();
        acc_data = 32'hC; acc_valid = bp_pat[4]; tick();
        acc_valid = bp_pat[5]; tick();
        chk("bp_ready_off", 32'(acc_ready), 32'd0);
        acc_data = 32'hD; acc_valid = 1'b1; tick();
        chk("bp_rr_in_held", rr_in, 32'hC);
        acc_valid = 1'b0;
        wait_done(10);
        tick();
        chk("bp_wr_count", 32'(wa_q.size()), 32'd3);
        chk_wr(0, 8'h20, 16'h00F5, 2);
        chk_wr(1, 8'h21, 16'h00F4, 5);
        chk_wr(2, 8'h22, 16'h00F3, 7);
        chk("bp_done_count", 32'(dn_q.size()), 32'd1);

        // Address wrap at 0xFE
        clr();
        do_start(9'd3, 8'hFE);
        acc_valid = 1'b1;
        acc_data = 32'h1; tick();
        acc_data = 32'h2; tick();
        acc_data = 32'h3; tick();
        acc_valid = 1'b0;
        wait_done(10);
        tick();
        chk("wrap_wr_count", 32'(wa_q.size()), 32'd3);
        chk_wr(0, 8'hFE, 16'h00FE, 2);
        chk_wr(1, 8'hFF, 16'h00FD, 3);
        chk_wr(2, 8'h00, 16'h00FC, 4);

        // Saturation count: rr_out forced to 7FFF,1234,8000,7FFF
        clr();
        sat_mode = 1'b1;
        do_start(9'd4, 8'h30);
        acc_valid = 1'b1;
        acc_data = 32'h0; tick();
        acc_data = 32'h1; tick();
        acc_data = 32'h2; tick();
        acc_data = 32'h3; tick();
        acc_valid = 1'b0;
        wait_done(10);
`ifdef RELU_ROUND_CTRL_SATCNT_EN
        chk("sat_at_done", 32'(sat_count), 32'd3);
        tick(); tick();
        chk("sat_held", 32'(sat_count), 32'd3);
`else
        chk("sat_at_done", 32'(sat_count), 32'd0);
        tick(); tick();
        chk("sat_held", 32'(sat_count), 32'd0);
`endif
        chk_wr(0, 8'h30, 16'h7FFF, 2);
        chk_wr(1, 8'h31, 16'h1234, 3);
        chk_wr(2, 8'h32, 16'h8000, 4);
        chk_wr(3, 8'h33, 16'h7FFF, 5);
        sat_mode = 1'b0;

        // Empty layer: done the cycle after start, no writes
        clr();
        do_start(9'd0, 8'h55);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_busy", 32'(busy), 32'd1);
        chk("empty_sat_clr", 32'(sat_count), 32'd0);
        tick();
        chk("empty_done_off", 32'(done), 32'd0);
        chk("empty_busy_off", 32'(busy), 32'd0);
        tick();
        chk("empty_wr_count", 32'(wa_q.size()), 32'd0);
        chk("empty_done_count", 32'(dn_q.size()), 32'd1);

        // Ignored start during RUN of an 8-entry layer
        clr();
        do_start(9'd8, 8'h40);
        acc_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            acc_data  = 32'(i + 1);
            start     = (i == 2);
            num_out   = (i == 2) ? 9'd2 : 9'd8;
            base_addr = (i == 2) ? 8'h90 : 8'h40;
            tick();
        end
        start = 1'b0; acc_valid = 1'b0;
        wait_done(12);
        tick(); tick(); tick();
        chk("ign_wr_count", 32'(wa_q.size()), 32'd8);
        chk_wr(0, 8'h40, 16'h00FE, 2);
        chk_wr(3, 8'h43, 16'h00FB, 5);
        chk_wr(7, 8'h47, 16'h00F7, 9);
        chk("ign_done_count", 32'(dn_q.size()), 32'd1);
        if (dn_q.size() > 0) chk("ign_done_cycle", 32'(dn_q[0] - t0), 32'd10);

        // Reset after 2 of 5 accepts
        clr();
        do_start(9'd5, 8'h60);
        acc_valid = 1'b1;
        acc_data = 32'h1; tick();
        acc_data = 32'h2; tick();
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        clr();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_wr_en", 32'(wr_en), 32'd0);
            chk("rst_hold_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_ready", 32'(acc_ready), 32'd0);
        end
        acc_valid = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_wr_count", 32'(wa_q.size()), 32'd0);
        chk("post_rst_done_count", 32'(dn_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
